fifo_rd_stream: RTL

- Read-side drain stage of the async FIFO. Sits directly downstream of the read-pointer/empty logic and the dual-port memory read port.
- Issues the `rd_inc` pop strobe and absorbs the memory's fixed read latency in a small output buffer.
- Presents FIFO words to the read-domain consumer as a `valid`/`ready` stream at up to one word per clock.
- Provides flush, buffer-level and delivered-word-count outputs.

---
 rtl/fifo_rd_stream.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
//==============================================================================
// Module   : fifo_rd_stream
// Brief    : Async FIFO read-side drain: issues pops, absorbs memory read
//            latency in a credit-sized buffer, presents a valid/ready stream.
// Revision : 1.0
//==============================================================================
`default_nettype none

module fifo_rd_stream #(
    parameter int  DATA_W    = 8,
    parameter int  RD_LAT    = 1,
    parameter int  CNT_W     = 16,
    localparam int BUF_DEPTH = RD_LAT + 1,
    localparam int LVL_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_inc,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              flush,
    output logic [LVL_W-1:0]  buf_lvl,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int               SUM_W    = $clog2(2 * BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_W-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [LVL_W-1:0]  r_lvl;
    logic [RD_LAT-1:0] r_inflight;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [CNT_W-1:0]  r_word_cnt;

    logic              w_pop;
    logic              w_ret;
    logic              w_push;
    logic [SUM_W-1:0]  w_inflight_cnt;
    logic [SUM_W-1:0]  w_credit;
    logic [RD_LAT-1:0] w_inflight_shift;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [LVL_W-1:0]  w_lvl_nxt;
    logic [DATA_W-1:0] w_head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = r_m_valid & m_ready;
    assign w_ret  = r_inflight[RD_LAT-1];
    assign w_push = w_ret & ~flush;

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + SUM_W'(r_inflight[i]);
        end
    end

    // Every outstanding read already owns a buffer slot, so the buffer cannot overflow.
    assign w_credit = SUM_W'(r_lvl) + w_inflight_cnt - SUM_W'(w_pop);
    assign rd_inc   = ~empty & ~flush & ~rd_rst & (w_credit < SUM_W'(BUF_DEPTH));

    if (RD_LAT == 1) begin : g_lat_one
        assign w_inflight_shift = rd_inc;
    end else begin : g_lat_multi
        assign w_inflight_shift = {r_inflight[RD_LAT-2:0], rd_inc};
    end

    always_comb begin
        w_rd_ptr_nxt = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_wr_ptr_nxt = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_lvl_nxt    = r_lvl + LVL_W'(w_push) - LVL_W'(w_pop);
        // When the buffer drains to its last word, the new head bypasses memory.
        w_head_nxt   = (r_lvl == LVL_W'(w_pop)) ? rd_data : r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge rd_clk) begin
        if (w_push && !rd_rst) begin
            r_mem[r_wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_lvl      <= '0;
            r_inflight <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_lvl      <= '0;
                r_inflight <= '0;
                r_m_valid  <= 1'b0;
            end else begin
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_wr_ptr   <= w_wr_ptr_nxt;
                r_lvl      <= w_lvl_nxt;
                r_inflight <= w_inflight_shift;
                r_m_valid  <= (w_lvl_nxt != '0);
                if ((w_lvl_nxt != '0) && (w_pop || (r_lvl == '0))) begin
                    r_m_data <= w_head_nxt;
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(w_push && !w_pop && (r_lvl == LVL_W'(BUF_DEPTH))));

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign buf_lvl  = r_lvl;
    assign word_cnt = r_word_cnt;

endmodule

`default_nettype wire
